// File: rtl/bus_matrix_pkg.sv
// Shared defines for the bus matrix: bus widths, the default slave-select
// field, the arbiter state encoding and the debug view of the arbiter.
package bus_matrix_pkg;

    localparam int MEM_ADDR_BUS = 32;
    localparam int MEM_BUS      = 32;
    localparam logic [MEM_BUS-1:0] ZERO_WORD = '0;

    localparam int SEL_MSB_DEF = 31;
    localparam int SEL_LSB_DEF = 28;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Fixed-width snapshot of the arbiter registers, zero-extended.
    typedef struct packed {
        state_t     state;
        logic [2:0] owner;
        logic [2:0] rr_ptr;
        logic [7:0] burst;
    } dbg_t;

endpackage

// File: rtl/bus_matrix_rr_pick.sv
// Round-robin picker: returns the first set bit of req at or after ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        int best;
        int d;
        best  = N;
        d     = 0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            // Distance from ptr to i walking upward with wrap.
            d = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N - int'(ptr));
            if (req[i] && d < best) begin
                best  = d;
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_matrix.sv
// Multi-master to multi-slave shared bus with round-robin arbitration,
// burst-limited ownership and address-window slave decode.
module bus_matrix
    import bus_matrix_pkg::*;
#(
    parameter int MASTERS   = 2,
    parameter int SLAVES    = 4,
    parameter int SEL_MSB   = SEL_MSB_DEF,
    parameter int SEL_LSB   = SEL_LSB_DEF,
    parameter int MAX_BURST = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MASTERS-1:0]          m_req_i,
    input  logic [MASTERS-1:0]          m_we_i,
    input  logic [MASTERS*MEM_ADDR_BUS-1:0] m_addr_i,
    input  logic [MASTERS*MEM_BUS-1:0]  m_wdata_i,
    output logic [MASTERS*MEM_BUS-1:0]  m_rdata_o,
    output logic [MASTERS-1:0]          m_gnt_o,
    output logic [MASTERS-1:0]          m_err_o,
    output logic [SLAVES-1:0]           s_sel_o,
    output logic [MEM_ADDR_BUS-1:0]     s_addr_o,
    output logic [MEM_BUS-1:0]          s_wdata_o,
    output logic                        s_we_o,
    input  logic [SLAVES*MEM_BUS-1:0]   s_rdata_i,
    output logic                        hold_flag_o,
    output dbg_t                        dbg_o
);

    localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int SW = SEL_MSB - SEL_LSB + 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    state_t             state;
    logic [MW-1:0]      owner;
    logic [MW-1:0]      rr_ptr;
    logic [BW-1:0]      burst;

    logic               busy;
    logic [MW-1:0]      next_ptr;
    logic               own_req;
    logic               others;
    logic               release_now;
    logic [MASTERS-1:0] pick_req;
    logic [MW-1:0]      pick_ptr;
    logic [MW-1:0]      pick_idx;
    logic               pick_valid;
    logic [MASTERS-1:0] pick_oh;

    logic [MEM_ADDR_BUS-1:0] own_addr;
    logic [MEM_BUS-1:0]      own_wdata;
    logic                    own_we;
    logic [SW-1:0]           sel_idx;
    logic                    mapped;
    logic [MEM_BUS-1:0]      rd_word;

    assign busy     = (state == BUSY);
    assign next_ptr = (owner == MW'(MASTERS - 1)) ? '0 : owner + 1'b1;
    // While busy m_gnt_o is the one-hot owner, so it doubles as the owner mask.
    assign own_req  = |(m_req_i & m_gnt_o);
    assign others   = |(m_req_i & ~m_gnt_o);
    assign release_now = ~own_req | ((burst == BURST_LAST) & others);

    // Busy: search for a successor starting after the owner; idle: from rr_ptr.
    assign pick_req = busy ? (m_req_i & ~m_gnt_o) : m_req_i;
    assign pick_ptr = busy ? next_ptr : rr_ptr;

    rr_pick #(.N(MASTERS), .W(MW)) u_rr_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        for (int i = 0; i < MASTERS; i++) begin
            pick_oh[i] = (pick_idx == MW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= '0;
            rr_ptr  <= '0;
            burst   <= '0;
            m_gnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= BUSY;
                        owner   <= pick_idx;
                        m_gnt_o <= pick_oh;
                        burst   <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        rr_ptr <= next_ptr;
                        burst  <= '0;
                        if (pick_valid) begin
                            owner   <= pick_idx;
                            m_gnt_o <= pick_oh;
                        end else begin
                            state   <= IDLE;
                            m_gnt_o <= '0;
                        end
                    end else if (burst != BURST_LAST) begin
                        burst <= burst + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        own_addr  = ZERO_WORD;
        own_wdata = ZERO_WORD;
        own_we    = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            if (owner == MW'(i)) begin
                own_addr  = m_addr_i[i*MEM_ADDR_BUS +: MEM_ADDR_BUS];
                own_wdata = m_wdata_i[i*MEM_BUS +: MEM_BUS];
                own_we    = m_we_i[i];
            end
        end
    end

    assign sel_idx = own_addr[SEL_MSB:SEL_LSB];
    assign mapped  = (int'(sel_idx) < SLAVES);

    always_comb begin
        rd_word = ZERO_WORD;
        s_sel_o = '0;
        for (int j = 0; j < SLAVES; j++) begin
            if (sel_idx == SW'(j)) begin
                rd_word    = s_rdata_i[j*MEM_BUS +: MEM_BUS];
                s_sel_o[j] = busy;
            end
        end
    end

    // A reset arriving mid-transfer kills the write strobe in that same cycle.
    always_comb begin
        s_addr_o  = ZERO_WORD;
        s_wdata_o = ZERO_WORD;
        s_we_o    = 1'b0;
        m_rdata_o = '0;
        m_err_o   = '0;
        if (busy && mapped) begin
            s_addr_o  = own_addr;
            s_wdata_o = own_wdata;
            s_we_o    = own_we & ~rst;
        end
        for (int i = 0; i < MASTERS; i++) begin
            if (busy && owner == MW'(i)) begin
                m_rdata_o[i*MEM_BUS +: MEM_BUS] = mapped ? rd_word : ZERO_WORD;
                m_err_o[i] = ~mapped;
            end
        end
    end

    assign hold_flag_o = |(m_req_i & ~m_gnt_o);

    assign dbg_o.state  = state;
    assign dbg_o.owner  = 3'(owner);
    assign dbg_o.rr_ptr = 3'(rr_ptr);
    assign dbg_o.burst  = 8'(burst);

endmodule

// File: tb/tb_bus_matrix.sv
// Randomized scoreboard bench for bus_matrix: a cycle-level reference model
// pushes expected outputs, a negedge monitor pops and compares them.
module tb_bus_matrix;
  import bus_matrix_pkg::*;

  localparam int M  = 2;
  localparam int S  = 4;
  localparam int MB = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [M-1:0]    m_req, m_we;
  logic [M*32-1:0] m_addr, m_wdata, m_rdata;
  logic [M-1:0]    m_gnt, m_err;
  logic [S-1:0]    s_sel;
  logic [31:0]     s_addr, s_wdata;
  logic            s_we;
  logic [S*32-1:0] s_rdata;
  logic            hold;
  dbg_t            dbg;

  bus_matrix #(.MASTERS(M), .SLAVES(S), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_rdata_o(m_rdata), .m_gnt_o(m_gnt), .m_err_o(m_err),
    .s_sel_o(s_sel), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_we_o(s_we),
    .s_rdata_i(s_rdata), .hold_flag_o(hold), .dbg_o(dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [M-1:0]    gnt;
    logic [M-1:0]    err;
    logic [S-1:0]    sel;
    logic            we;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [M*32-1:0] rdata;
    logic            hold;
    logic [2:0]      ptr;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the bus, where round-robin resumes, and how
  // many consecutive cycles the owner has held it.
  int own = -1;
  int ptr = 0;
  int run = 0;

  function automatic int find_from(int start, logic [M-1:0] req, int skip);
    for (int k = 0; k < M; k++) begin
      int c;
      c = (start + k) % M;
      if (c != skip && req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_edge();
    if (rst) begin
      own = -1; ptr = 0; run = 0;
    end else if (own < 0) begin
      own = find_from(ptr, m_req, -1);
      run = 1;
    end else begin
      bit others;
      others = 1'b0;
      for (int i = 0; i < M; i++) if (i != own && m_req[i]) others = 1'b1;
      if (!m_req[own] || (run >= MB && others)) begin
        ptr = (own + 1) % M;
        own = find_from(ptr, m_req, own);
        run = 1;
      end else begin
        run++;
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e = '0;
    if (own >= 0) begin
      logic [31:0] a;
      int idx;
      e.gnt[own] = 1'b1;
      a = m_addr[own*32 +: 32];
      idx = int'(a[31:28]);
      if (idx < S) begin
        e.sel[idx] = 1'b1;
        e.addr  = a;
        e.wdata = m_wdata[own*32 +: 32];
        e.we    = m_we[own] & ~rst;
        e.rdata[own*32 +: 32] = s_rdata[idx*32 +: 32];
      end else begin
        e.err[own] = 1'b1;
      end
    end
    e.hold = |(m_req & ~e.gnt);
    e.ptr  = 3'(ptr);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are combinational on the current inputs, so compare
  // mid-cycle against the expectation queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("gnt",    64'(m_gnt),      64'(e.gnt));
      chk("err",    64'(m_err),      64'(e.err));
      chk("sel",    64'(s_sel),      64'(e.sel));
      chk("we",     64'(s_we),       64'(e.we));
      chk("addr",   64'(s_addr),     64'(e.addr));
      chk("wdata",  64'(s_wdata),    64'(e.wdata));
      chk("rdata",  64'(m_rdata),    64'(e.rdata));
      chk("hold",   64'(hold),       64'(e.hold));
      chk("rr_ptr", 64'(dbg.rr_ptr), 64'(e.ptr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    push_expect();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_m(int i, bit req, bit we, logic [31:0] addr, logic [31:0] wd);
    m_req[i] = req;
    m_we[i]  = we;
    m_addr[i*32 +: 32]  = addr;
    m_wdata[i*32 +: 32] = wd;
  endtask

  task automatic idle(int n);
    m_req = '0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic rand_rdata();
    for (int j = 0; j < S; j++) s_rdata[j*32 +: 32] = $urandom;
  endtask

  task automatic rand_addr(int i);
    m_addr[i*32 +: 32] = {4'($urandom_range(0, 7)), 28'($urandom)};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; s_rdata = '0;
    repeat (2) @(posedge clk);
    model_edge();
    #1;
    cycle();
    rst = 1'b0;

    // Master 0 reads slave 1.
    s_rdata[32 +: 32] = 32'hDEADBEEF;
    set_m(0, 1'b1, 1'b0, 32'h1000_0004, 32'h0);
    repeat (3) cycle();
    idle(2);

    // Master 1 writes 0x5A to slave 2 while master 0 is idle.
    set_m(1, 1'b1, 1'b1, 32'h2000_0000, 32'h5A);
    repeat (4) cycle();
    idle(2);

    // Unmapped window.
    set_m(0, 1'b1, 1'b0, 32'h7000_0000, 32'h0);
    repeat (3) cycle();
    idle(2);

    // Both masters requesting continuously: 8-cycle alternation.
    set_m(0, 1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111);
    set_m(1, 1'b1, 1'b0, 32'h3000_0020, 32'h2222_2222);
    repeat (40) begin rand_rdata(); cycle(); end
    idle(2);

    // Master 0 holds 3 cycles with master 1 pending: direct handoff.
    set_m(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    cycle();
    set_m(1, 1'b1, 1'b1, 32'h2000_0008, 32'hA5A5_0001);
    repeat (2) cycle();
    m_req[0] = 1'b0;
    repeat (3) cycle();
    idle(2);

    // Reset mid-burst, then a simultaneous request must go to master 0.
    set_m(1, 1'b1, 1'b1, 32'h0000_0000, 32'h0BAD_0BAD);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    m_req = '0;
    cycle();
    set_m(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
    repeat (4) cycle();
    idle(2);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < M; i++) begin
        if (m_req[i]) m_req[i] = ($urandom_range(0, 9) != 0);
        else          m_req[i] = ($urandom_range(0, 2) == 0);
        m_we[i] = 1'($urandom);
        rand_addr(i);
        m_wdata[i*32 +: 32] = $urandom;
      end
      rand_rdata();
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    idle(2);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
